// File: rtl/hack_keyboard.sv
// hack_keyboard
//   Turns MiSTer ps2_key events (from hps_io) into the 16-bit value of the
//   Hack KBD register (0x6000). Held non-modifier keys live in a small
//   most-recent-first stack, so releasing the top key reveals the next held
//   one. Shift (left/right) and caps-lock state are tracked separately and
//   applied when the top entry is translated.
//
// Ports
//   clk_sys      system clock
//   reset_n      synchronous active-low reset
//   ps2_key      [10] toggles per event, [9] 1=press/0=release,
//                [8] E0-extended, [7:0] set-2 scancode
//   key_code     Hack code of the top held key, 0 when nothing is held
//   key_changed  one-cycle pulse in the cycle key_code takes a new value
//   caps_lock    current caps-lock state
//
// Timing: ps2_key is registered once; the event is applied and key_code is
// registered on the following edge (two clk_sys edges in total).

module hack_keyboard #(
    parameter int DEPTH = 4
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    output logic [15:0] key_code,
    output logic        key_changed,
    output logic        caps_lock
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    typedef logic [8:0] key_t;   // {ext, scancode}

    localparam key_t KEY_LSHIFT = 9'h012;
    localparam key_t KEY_RSHIFT = 9'h059;
    localparam key_t KEY_CAPS   = 9'h058;

    // Translate {ext, scancode} into an 8-bit Hack code; 0 means unmapped.
    function automatic logic [7:0] map_code(input key_t key, input logic shift,
                                            input logic caps);
        logic [7:0] letter;
        logic [7:0] code;
        letter = 8'h00;
        code   = 8'h00;
        case (key)
            9'h01C: letter = "a";   9'h032: letter = "b";
            9'h021: letter = "c";   9'h023: letter = "d";
            9'h024: letter = "e";   9'h02B: letter = "f";
            9'h034: letter = "g";   9'h033: letter = "h";
            9'h043: letter = "i";   9'h03B: letter = "j";
            9'h042: letter = "k";   9'h04B: letter = "l";
            9'h03A: letter = "m";   9'h031: letter = "n";
            9'h044: letter = "o";   9'h04D: letter = "p";
            9'h015: letter = "q";   9'h02D: letter = "r";
            9'h01B: letter = "s";   9'h02C: letter = "t";
            9'h03C: letter = "u";   9'h02A: letter = "v";
            9'h01D: letter = "w";   9'h022: letter = "x";
            9'h035: letter = "y";   9'h01A: letter = "z";
            default: letter = 8'h00;
        endcase

        if (letter != 8'h00) begin
            // Caps-lock inverts the shift sense for letters only.
            code = (shift ^ caps) ? letter - 8'd32 : letter;
        end else begin
            case (key)
                9'h016: code = shift ? "!" : "1";
                9'h01E: code = shift ? "@" : "2";
                9'h026: code = shift ? "#" : "3";
                9'h025: code = shift ? "$" : "4";
                9'h02E: code = shift ? "%" : "5";
                9'h036: code = shift ? "^" : "6";
                9'h03D: code = shift ? "&" : "7";
                9'h03E: code = shift ? "*" : "8";
                9'h046: code = shift ? "(" : "9";
                9'h045: code = shift ? ")" : "0";
                9'h04E: code = shift ? "_" : "-";
                9'h055: code = shift ? "+" : "=";
                9'h054: code = shift ? "{" : "[";
                9'h05B: code = shift ? "}" : "]";
                9'h05D: code = shift ? 8'h7C : 8'h5C;   // | and backslash
                9'h04C: code = shift ? ":" : ";";
                9'h052: code = shift ? 8'h22 : 8'h27;   // double / single quote
                9'h041: code = shift ? "<" : ",";
                9'h049: code = shift ? ">" : ".";
                9'h04A: code = shift ? "?" : "/";
                9'h029: code = 8'd32;                   // space
                9'h05A: code = 8'd128;                  // enter
                9'h066: code = 8'd129;                  // backspace
                9'h16B: code = 8'd130;                  // left
                9'h175: code = 8'd131;                  // up
                9'h174: code = 8'd132;                  // right
                9'h172: code = 8'd133;                  // down
                9'h16C: code = 8'd134;                  // home
                9'h169: code = 8'd135;                  // end
                9'h17D: code = 8'd136;                  // page up
                9'h17A: code = 8'd137;                  // page down
                9'h170: code = 8'd138;                  // insert
                9'h171: code = 8'd139;                  // delete
                9'h076: code = 8'd140;                  // escape
                9'h005: code = 8'd141;                  // F1
                9'h006: code = 8'd142;                  // F2
                9'h004: code = 8'd143;                  // F3
                9'h00C: code = 8'd144;                  // F4
                9'h003: code = 8'd145;                  // F5
                9'h00B: code = 8'd146;                  // F6
                9'h083: code = 8'd147;                  // F7
                9'h00A: code = 8'd148;                  // F8
                9'h001: code = 8'd149;                  // F9
                9'h009: code = 8'd150;                  // F10
                9'h078: code = 8'd151;                  // F11
                9'h007: code = 8'd152;                  // F12
                default: code = 8'h00;
            endcase
        end
        return code;
    endfunction

    // Input stage and event detection
    logic [10:0] ps2_q;
    logic        tog_q;
    logic        ev_valid;
    logic        ev_press;
    key_t        ev_key;

    assign ev_valid = ps2_q[10] != tog_q;
    assign ev_press = ps2_q[9];
    assign ev_key   = ps2_q[8:0];

    // Held-key stack: index 0 is the most recent press; only the first
    // count_q entries are meaningful.
    key_t             stack_q [DEPTH];
    key_t             stack_d [DEPTH];
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;
    logic             shift_l_q, shift_l_d;
    logic             shift_r_q, shift_r_d;
    logic             caps_d;
    logic             hit;
    int               hit_idx;
    logic [7:0]       top_code;
    logic [15:0]      code_d;

    always_comb begin
        // NOTE: every variable gets a default first so no path leaves one
        // unassigned, which would otherwise infer a latch.
        stack_d   = stack_q;
        count_d   = count_q;
        shift_l_d = shift_l_q;
        shift_r_d = shift_r_q;
        caps_d    = caps_lock;
        hit       = 1'b0;
        hit_idx   = 0;
        top_code  = 8'h00;

        for (int i = 0; i < DEPTH; i++) begin
            if ((CNT_W'(i) < count_q) && (stack_q[i] == ev_key)) begin
                hit     = 1'b1;
                hit_idx = i;
            end
        end

        if (ev_valid) begin
            if (ev_key == KEY_LSHIFT) begin
                shift_l_d = ev_press;
            end else if (ev_key == KEY_RSHIFT) begin
                shift_r_d = ev_press;
            end else if (ev_key == KEY_CAPS) begin
                if (ev_press) caps_d = ~caps_lock;
            end else if (map_code(ev_key, 1'b0, 1'b0) != 8'h00) begin
                if (ev_press && !hit) begin
                    // Push on top; when full the bottom entry falls off.
                    for (int i = DEPTH - 1; i > 0; i--) stack_d[i] = stack_q[i - 1];
                    stack_d[0] = ev_key;
                    if (count_q != CNT_W'(DEPTH)) count_d = count_q + 1'b1;
                end else if (!ev_press && hit) begin
                    // Close the gap left by the released key, keeping order.
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        if (i >= hit_idx) stack_d[i] = stack_q[i + 1];
                    end
                    count_d = count_q - 1'b1;
                end
            end
        end

        // Translate from the post-event state so modifiers act immediately.
        if (count_d != '0) top_code = map_code(stack_d[0], shift_l_d | shift_r_d, caps_d);
    end

    assign code_d = {8'h00, top_code};

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_sys) begin
        ps2_q <= ps2_key;
        if (!reset_n) begin
            // Prime the toggle history so leaving reset is not seen as an event.
            tog_q       <= ps2_key[10];
            count_q     <= '0;
            shift_l_q   <= 1'b0;
            shift_r_q   <= 1'b0;
            caps_lock   <= 1'b0;
            key_code    <= 16'h0000;
            key_changed <= 1'b0;
        end else begin
            tog_q       <= ps2_q[10];
            count_q     <= count_d;
            shift_l_q   <= shift_l_d;
            shift_r_q   <= shift_r_d;
            caps_lock   <= caps_d;
            key_code    <= code_d;
            key_changed <= code_d != key_code;
        end
    end

    // NOTE: the stack contents are not reset; count_q alone decides which
    // entries are valid, so stale data is never observed.
    always_ff @(posedge clk_sys) begin
        stack_q <= stack_d;
    end

endmodule

// File: tb/tb_hack_keyboard.sv
// tb_hack_keyboard
//   Drives ps2_key events, runs a reference model of the held-key stack and
//   modifiers, and queues the expected key_code / key_changed / caps_lock
//   for the cycle before, of and after each event takes effect. A monitor
//   on the falling clock edge pops and compares them, and requires
//   key_changed low on every other cycle.

module tb_hack_keyboard;

    localparam int DEPTH = 4;

    logic        clk_sys = 1'b0;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic [15:0] key_code;
    logic        key_changed;
    logic        caps_lock;

    hack_keyboard #(.DEPTH(DEPTH)) dut (
        .clk_sys    (clk_sys),
        .reset_n    (reset_n),
        .ps2_key    (ps2_key),
        .key_code   (key_code),
        .key_changed(key_changed),
        .caps_lock  (caps_lock)
    );

    always #5 clk_sys = ~clk_sys;

    int cyc = 0;
    always @(posedge clk_sys) cyc <= cyc + 1;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
    endtask

    // Scoreboard
    typedef struct {
        int          due;
        logic [15:0] code;
        logic        pulse;
        logic        caps;
    } exp_t;

    exp_t sb[$];

    task automatic push_exp(input int due, input logic [15:0] code, input logic pulse,
                            input logic caps);
        exp_t e;
        e.due = due; e.code = code; e.pulse = pulse; e.caps = caps;
        sb.push_back(e);
    endtask

    always @(negedge clk_sys) begin
        if (cyc > 0) begin
            if (sb.size() == 0 || sb[0].due != cyc) check("idle_pulse", 32'(key_changed), 0);
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                check("key_code",    32'(key_code),    32'(e.code));
                check("key_changed", 32'(key_changed), 32'(e.pulse));
                check("caps_lock",   32'(caps_lock),   32'(e.caps));
            end
        end
    end

    // Reference model
    logic [8:0]  m_stk[$];
    logic        m_lsh = 1'b0, m_rsh = 1'b0, m_caps = 1'b0;
    logic [15:0] m_code = 16'h0000;

    // Only keys the stimulus uses; anything else counts as unmapped.
    function automatic logic [7:0] ref_map(input logic [8:0] k, input logic sh, input logic cp);
        case (k)
            9'h01C: return (sh ^ cp) ? 8'h41 : 8'h61;
            9'h032: return (sh ^ cp) ? 8'h42 : 8'h62;
            9'h021: return (sh ^ cp) ? 8'h43 : 8'h63;
            9'h023: return (sh ^ cp) ? 8'h44 : 8'h64;
            9'h024: return (sh ^ cp) ? 8'h45 : 8'h65;
            9'h016: return sh ? 8'h21 : 8'h31;
            9'h04E: return sh ? 8'h5F : 8'h2D;
            9'h029: return 8'd32;
            9'h05A: return 8'd128;
            9'h066: return 8'd129;
            9'h16B: return 8'd130;
            9'h175: return 8'd131;
            9'h076: return 8'd140;
            9'h005: return 8'd141;
            9'h083: return 8'd147;
            default: return 8'd0;
        endcase
    endfunction

    task automatic model_event(input logic press, input logic [8:0] k);
        int idx;
        idx = -1;
        if (k == 9'h012) m_lsh = press;
        else if (k == 9'h059) m_rsh = press;
        else if (k == 9'h058) begin
            if (press) m_caps = ~m_caps;
        end else if (ref_map(k, 1'b0, 1'b0) != 8'd0) begin
            for (int i = 0; i < m_stk.size(); i++) if (m_stk[i] == k) idx = i;
            if (press && idx < 0) begin
                m_stk.push_front(k);
                if (m_stk.size() > DEPTH) void'(m_stk.pop_back());
            end else if (!press && idx >= 0) begin
                m_stk.delete(idx);
            end
        end
        m_code = (m_stk.size() > 0) ? {8'h00, ref_map(m_stk[0], m_lsh | m_rsh, m_caps)} : 16'h0000;
    endtask

    task automatic send(input logic press, input logic ext, input logic [7:0] sc);
        int          n;
        logic [15:0] prev;
        logic        prev_caps;
        @(negedge clk_sys);
        n         = cyc;
        ps2_key   = {~ps2_key[10], press, ext, sc};
        prev      = m_code;
        prev_caps = m_caps;
        model_event(press, {ext, sc});
        push_exp(n + 1, prev, 1'b0, prev_caps);
        push_exp(n + 2, m_code, m_code != prev, m_caps);
        push_exp(n + 3, m_code, 1'b0, m_caps);
        repeat (2) @(negedge clk_sys);
    endtask

    task automatic tap(input logic ext, input logic [7:0] sc);
        send(1'b1, ext, sc);
        send(1'b0, ext, sc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int n;
        reset_n = 1'b0;
        ps2_key = 11'h000;
        for (int i = 1; i <= 3; i++) push_exp(i, 16'h0000, 1'b0, 1'b0);
        repeat (3) @(negedge clk_sys);
        reset_n = 1'b1;

        // Single letter press/release
        tap(1'b0, 8'h1C);

        // Shift, caps-lock, digits and symbols
        send(1, 0, 8'h12); send(1, 0, 8'h1C); send(0, 0, 8'h12); send(0, 0, 8'h1C);
        tap(0, 8'h58);
        send(1, 0, 8'h16); send(0, 0, 8'h16);
        send(1, 0, 8'h12); send(1, 0, 8'h16); send(0, 0, 8'h16);
        send(1, 0, 8'h4E); send(0, 0, 8'h4E); send(0, 0, 8'h12);
        send(1, 0, 8'h1C); send(1, 0, 8'h59); send(0, 0, 8'h59); send(0, 0, 8'h1C);
        tap(0, 8'h58);

        // Rollover and typematic repeat
        send(1, 0, 8'h1C); send(1, 0, 8'h32); send(0, 0, 8'h32); send(0, 0, 8'h1C);
        send(1, 0, 8'h1C); send(1, 0, 8'h1C); send(0, 0, 8'h1C);

        // Overflow past DEPTH entries
        send(1, 0, 8'h1C); send(1, 0, 8'h32); send(1, 0, 8'h21); send(1, 0, 8'h23);
        send(1, 0, 8'h24);
        send(0, 0, 8'h24); send(0, 0, 8'h1C); send(0, 0, 8'h21); send(0, 0, 8'h23);
        send(0, 0, 8'h32);

        // Extended keys, specials, unmapped keys
        send(1, 1, 8'h75); send(0, 1, 8'h75);
        send(1, 0, 8'h75); send(0, 0, 8'h75);
        send(1, 1, 8'h6B); send(1, 0, 8'h5A); send(0, 0, 8'h5A); send(0, 1, 8'h6B);
        send(1, 0, 8'h0E); send(0, 0, 8'h0E);
        send(1, 1, 8'h1C); send(0, 1, 8'h1C);
        tap(0, 8'h05); tap(0, 8'h83); tap(0, 8'h76); tap(0, 8'h29); tap(0, 8'h66);

        // Reset mid-operation with events in flight
        tap(0, 8'h58);
        send(1, 0, 8'h1C);
        @(negedge clk_sys);
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h32};
        @(negedge clk_sys);
        n       = cyc;
        reset_n = 1'b0;
        ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h21};
        m_stk.delete();
        m_lsh = 1'b0; m_rsh = 1'b0; m_caps = 1'b0; m_code = 16'h0000;
        for (int i = 1; i <= 4; i++) push_exp(n + i, 16'h0000, 1'b0, 1'b0);
        @(negedge clk_sys);
        reset_n = 1'b1;
        repeat (3) @(negedge clk_sys);
        send(0, 0, 8'h1C);
        send(1, 0, 8'h32); send(0, 0, 8'h32);

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk_sys);
        check("sb_drain", 32'(sb.size()), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
